// File: rtl/pcileech_tlps128_arb_pkg.sv
// Shared definitions for the 128-bit TLP transmit arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY)
//   GRANT_NONE  : grant index reported when no source owns the output
//   lowest_idx  : index of the lowest set bit of an 8-bit mask
//   rr_pick     : first set bit searching upward from ptr+1, wrapping at n
package pcileech_tlps128_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [3:0] GRANT_NONE = 4'hF;

    function automatic logic [3:0] lowest_idx(input logic [7:0] mask);
        logic [3:0] res;
        res = GRANT_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) res = 4'(i);
        end
        return res;
    endfunction

    // Walk from the far end back towards ptr+1 so the last hit is the
    // closest one above ptr.
    function automatic logic [3:0] rr_pick(input logic [7:0] mask,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [3:0] res;
        int         idx;
        res = GRANT_NONE;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            if (mask[idx[2:0]]) res = 4'(idx);
        end
        return res;
    endfunction

endpackage

// File: rtl/pcileech_tlps128_arb_pick.sv
// Combinational grant selector: starved sources first, then the strict
// class, then round-robin among the remaining eligible sources.
//   eligible_i   : sources that may be granted now
//   strict_i     : strict-priority class membership
//   starve_cnt_i : per-source starvation counts, 8 bits each
//   rr_ptr_i     : last round-robin winner
//   valid_o      : some source wins
//   idx_o        : winning index (GRANT_NONE when !valid_o)
//   is_rr_o      : the win came from the round-robin stage
module pcileech_tlps128_arb_pick
    import pcileech_tlps128_arb_pkg::*;
#(
    parameter int NUM_IN       = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic [NUM_IN-1:0]   eligible_i,
    input  logic [NUM_IN-1:0]   strict_i,
    input  logic [NUM_IN*8-1:0] starve_cnt_i,
    input  logic [2:0]          rr_ptr_i,
    output logic                valid_o,
    output logic [3:0]          idx_o,
    output logic                is_rr_o
);

    logic [NUM_IN-1:0] starved;
    logic [NUM_IN-1:0] strict_el;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            starved[i] = eligible_i[i] &&
                         (starve_cnt_i[i*8 +: 8] >= 8'(STARVE_LIMIT));
        end
        strict_el = eligible_i & strict_i;

        valid_o = |eligible_i;
        idx_o   = GRANT_NONE;
        is_rr_o = 1'b0;
        if (|starved) begin
            idx_o = lowest_idx(8'(starved));
        end else if (|strict_el) begin
            idx_o = lowest_idx(8'(strict_el));
        end else if (|eligible_i) begin
            idx_o   = rr_pick(8'(eligible_i), rr_ptr_i, NUM_IN);
            is_rr_o = 1'b1;
        end
    end

endmodule

// File: rtl/pcileech_tlps128_tx_arbiter.sv
// Packet-atomic arbiter sharing the 128-bit TLP transmit stream between
// NUM_IN sources. A grant lasts from the first beat to the tlast beat;
// re-arbitration happens on the accepted tlast beat so packets run
// back-to-back.
//   clk_pcie, rst_n        : clock, async active-low reset (release synced)
//   in_*                   : per-source TLP-AXI streams (flattened buses)
//   out_*                  : muxed stream towards the PCIe core
//   out_has_data           : some enabled source holds a packet
//   cfg_enable, cfg_strict : per-source enable / strict-class membership
//   grant_id               : current owner, GRANT_NONE when idle
//   pkt_cnt                : per-source completed-packet counters (16 bit)
//   dbg_state              : FSM state
//
// Handshake: a beat moves when out_tvalid && out_tready; the granted
// source sees in_tready == out_tready in the same cycle, all others 0.
module pcileech_tlps128_tx_arbiter
    import pcileech_tlps128_arb_pkg::*;
#(
    parameter int NUM_IN       = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk_pcie,
    input  logic                  rst_n,
    input  logic [NUM_IN-1:0]     in_has_data,
    input  logic [NUM_IN-1:0]     in_tvalid,
    input  logic [NUM_IN*128-1:0] in_tdata,
    input  logic [NUM_IN*4-1:0]   in_tkeepdw,
    input  logic [NUM_IN-1:0]     in_tlast,
    input  logic [NUM_IN*9-1:0]   in_tuser,
    output logic [NUM_IN-1:0]     in_tready,
    output logic [127:0]          out_tdata,
    output logic [3:0]            out_tkeepdw,
    output logic                  out_tlast,
    output logic [8:0]            out_tuser,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_has_data,
    input  logic [NUM_IN-1:0]     cfg_enable,
    input  logic [NUM_IN-1:0]     cfg_strict,
    output logic [3:0]            grant_id,
    output logic [NUM_IN*16-1:0]  pkt_cnt,
    output arb_state_t            dbg_state
);

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    arb_state_t           state_q, state_d;
    logic [3:0]           grant_q, grant_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_IN*8-1:0]  starve_q, starve_d;
    logic [NUM_IN*16-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [NUM_IN-1:0]    eligible;
    logic                 last_acc;
    logic                 pick_valid, pick_is_rr;
    logic [3:0]           pick_idx;

    assign eligible     = in_has_data & cfg_enable;
    assign out_has_data = |eligible;

    // Output mux driven from the registered grant only.
    always_comb begin
        out_tdata   = '0;
        out_tkeepdw = '0;
        out_tlast   = 1'b0;
        out_tuser   = '0;
        out_tvalid  = 1'b0;
        in_tready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (state_q == BUSY && grant_q == 4'(i)) begin
                out_tdata    = in_tdata[i*128 +: 128];
                out_tkeepdw  = in_tkeepdw[i*4 +: 4];
                out_tlast    = in_tlast[i];
                out_tuser    = in_tuser[i*9 +: 9];
                out_tvalid   = in_tvalid[i];
                in_tready[i] = out_tready;
            end
        end
    end

    assign last_acc = out_tvalid & out_tready & out_tlast;

    // Starvation and packet counters. The selector sees the post-completion
    // counts so a source reaching the limit on this completion wins now.
    always_comb begin
        starve_d  = starve_q;
        pkt_cnt_d = pkt_cnt_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!eligible[i]) begin
                starve_d[i*8 +: 8] = 8'd0;
            end else if (last_acc) begin
                if (grant_q == 4'(i))
                    starve_d[i*8 +: 8] = 8'd0;
                else if (starve_q[i*8 +: 8] != 8'hFF)
                    starve_d[i*8 +: 8] = starve_q[i*8 +: 8] + 8'd1;
            end
            if (last_acc && grant_q == 4'(i))
                pkt_cnt_d[i*16 +: 16] = pkt_cnt_q[i*16 +: 16] + 16'd1;
        end
    end

    pcileech_tlps128_arb_pick #(
        .NUM_IN       (NUM_IN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .eligible_i   (eligible),
        .strict_i     (cfg_strict),
        .starve_cnt_i (starve_d),
        .rr_ptr_i     (rr_ptr_q),
        .valid_o      (pick_valid),
        .idx_o        (pick_idx),
        .is_rr_o      (pick_is_rr)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE, BUSY: begin
                // Arbitrate while idle, or on the accepted last beat.
                if (state_q == IDLE || last_acc) begin
                    if (pick_valid) begin
                        state_d = BUSY;
                        grant_d = pick_idx;
                        if (pick_is_rr) rr_ptr_d = pick_idx[2:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = GRANT_NONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_pcie or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_NONE;
            rr_ptr_q  <= 3'(NUM_IN - 1);
            starve_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            starve_q  <= starve_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant_id  = grant_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign dbg_state = state_q;

endmodule
